// File: rtl/imm_extend_pipe.sv
// Registered immediate extender (zero/sign/upper/branch) feeding the ALU B-mux and branch adder.
// A 2-entry skid buffer with valid/ready on both sides decouples decode from downstream stalls.
module imm_extend_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int SHIFT_BR = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [IN_W-1:0]  Imm_In,
    input  logic [1:0]       Mode,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [OUT_W-1:0] Imm_Out,
    output logic [1:0]       Occupancy
);

    generate
        if (IN_W < 1) begin : g_bad_in_w
            $error("imm_extend_pipe: IN_W must be >= 1");
        end
        if (OUT_W <= IN_W) begin : g_bad_out_w
            $error("imm_extend_pipe: OUT_W must be greater than IN_W");
        end
        if (SHIFT_BR >= OUT_W) begin : g_bad_shift
            $error("imm_extend_pipe: SHIFT_BR must be less than OUT_W");
        end
    endgenerate

    localparam int EXT_W = OUT_W - IN_W;

    localparam logic [1:0] MODE_ZERO   = 2'b00;
    localparam logic [1:0] MODE_SIGN   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Handshake: a word moves on a rising edge only when valid and ready are both
    // high in the preceding cycle; valid never depends on ready, and In_Ready is
    // derived from registered occupancy (plus reset), never from Out_Ready.

    state_t             r_state;
    logic [OUT_W-1:0]   r_head;
    logic [OUT_W-1:0]   r_tail;

    state_t             w_state_nxt;
    logic [OUT_W-1:0]   w_head_nxt;
    logic [OUT_W-1:0]   w_tail_nxt;
    logic [OUT_W-1:0]   w_zext;
    logic [OUT_W-1:0]   w_sext;
    logic [OUT_W-1:0]   w_upper;
    logic [OUT_W-1:0]   w_branch;
    logic [OUT_W-1:0]   w_ext;
    logic               w_accept;
    logic               w_pop;

    assign w_zext   = {{EXT_W{1'b0}}, Imm_In};
    assign w_sext   = {{EXT_W{Imm_In[IN_W-1]}}, Imm_In};
    assign w_upper  = w_zext << EXT_W;
    assign w_branch = w_sext << SHIFT_BR;

    always_comb begin
        w_ext = w_zext;
        case (Mode)
            MODE_ZERO:   w_ext = w_zext;
            MODE_SIGN:   w_ext = w_sext;
            MODE_UPPER:  w_ext = w_upper;
            MODE_BRANCH: w_ext = w_branch;
            default:     w_ext = w_zext;
        endcase
    end

    assign In_Ready  = (r_state != ST_FULL) & ~Rst;
    assign Out_Valid = (r_state != ST_EMPTY);
    assign Occupancy = r_state;
    assign Imm_Out   = r_head;

    assign w_accept = In_Valid & In_Ready;
    assign w_pop    = Out_Valid & Out_Ready;

    // Vacated slots are cleared so Imm_Out reads zero whenever the buffer is empty.
    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_head_nxt  = w_ext;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_pop) begin
                    w_head_nxt = w_ext;
                end else if (w_accept) begin
                    w_tail_nxt  = w_ext;
                    w_state_nxt = ST_FULL;
                end else if (w_pop) begin
                    w_head_nxt  = '0;
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_head_nxt  = r_tail;
                    w_tail_nxt  = '0;
                    w_state_nxt = ST_ONE;
                end
            end
            default: begin
                w_head_nxt  = '0;
                w_tail_nxt  = '0;
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed + randomized bench for imm_extend_pipe; a queue-based reference model
// tracks buffer contents and every cycle's outputs are checked against it.
module tb_imm_extend_pipe;

    localparam int IN_W     = 16;
    localparam int OUT_W    = 32;
    localparam int SHIFT_BR = 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] imm_in;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] imm_out;
    logic [1:0]  occupancy;

    logic        v8;
    logic        rdy8_in;
    logic [7:0]  imm8;
    logic [1:0]  mode8;
    logic        ovalid8;
    logic        ordy8;
    logic [15:0] out8;
    logic [1:0]  occ8;

    logic [31:0] exp_q[$];
    logic [31:0] last_out;
    bit          last_acc;
    int          checks;
    int          errors;

    imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_BR(SHIFT_BR)) dut (
        .Clk(clk), .Rst(rst),
        .In_Valid(in_valid), .In_Ready(in_ready),
        .Imm_In(imm_in), .Mode(mode),
        .Out_Valid(out_valid), .Out_Ready(out_ready),
        .Imm_Out(imm_out), .Occupancy(occupancy)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16), .SHIFT_BR(1)) dut8 (
        .Clk(clk), .Rst(rst),
        .In_Valid(v8), .In_Ready(rdy8_in),
        .Imm_In(imm8), .Mode(mode8),
        .Out_Valid(ovalid8), .Out_Ready(ordy8),
        .Imm_Out(out8), .Occupancy(occ8)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: treat the immediate as an integer, apply the mode arithmetically,
    // reduce modulo 2**OUT_W.
    function automatic logic [31:0] ref_ext(input logic [1:0] m, input logic [15:0] imm);
        longint      u;
        longint      s;
        longint      r;
        logic [63:0] t;
        u = longint'(imm);
        s = (u >= (64'sd1 << (IN_W - 1))) ? u - (64'sd1 << IN_W) : u;
        case (m)
            2'd0:    r = u;
            2'd1:    r = s;
            2'd2:    r = u * (64'sd1 << (OUT_W - IN_W));
            default: r = s * (64'sd1 << SHIFT_BR);
        endcase
        t = r;
        return t[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model at the falling edge, then
    // advance the model across the rising edge.
    task automatic cyc();
        int          n;
        bit          acc;
        bit          pop;
        logic [1:0]  m;
        logic [15:0] d;
        @(negedge clk);
        n = exp_q.size();
        chk("in_ready", 32'(in_ready), 32'(!rst && n < 2));
        chk("out_valid", 32'(out_valid), 32'(n > 0));
        chk("occupancy", 32'(occupancy), 32'(n));
        chk("imm_out", imm_out, (n > 0) ? exp_q[0] : 32'h0);
        last_out = imm_out;
        acc = in_valid && !rst && n < 2;
        pop = out_ready && !rst && n > 0;
        m = mode;
        d = imm_in;
        last_acc = acc;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(ref_ext(m, d));
        end
        #1;
    endtask

    logic [1:0]  t2_mode[5] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd3};
    logic [15:0] t2_imm[5]  = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h4000};
    logic [31:0] t2_exp[5]  = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFFC, 32'h00010000};

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [15:0] d;
        bit          got;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode      = 2'd0;
        imm_in    = 16'h0;
        v8        = 1'b0;
        ordy8     = 1'b1;
        imm8      = 8'h0;
        mode8     = 2'd0;
        last_out  = 32'h0;
        last_acc  = 1'b0;

        // reset held for two cycles
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        imm_in   = 16'hABCD;
        cyc();
        cyc();
        chk("rst8_occ", 32'(occ8), 32'h0);
        chk("rst8_valid", 32'(ovalid8), 32'h0);
        in_valid = 1'b0;
        rst      = 1'b0;
        cyc();

        // directed modes with consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            mode     = t2_mode[i];
            imm_in   = t2_imm[i];
            cyc();
            in_valid = 1'b0;
            cyc();
            chk($sformatf("mode_vec%0d", i), last_out, t2_exp[i]);
        end

        // backpressure: third word must wait until space frees
        out_ready = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        c = 16'($urandom);
        in_valid = 1'b1;
        mode = 2'($urandom_range(0, 3));
        imm_in = a;
        cyc();
        imm_in = b;
        cyc();
        imm_in = c;
        cyc();
        cyc();
        chk("bp_full", 32'(occupancy), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            cyc();
            got = last_acc;
        end
        chk("bp_c_accepted", 32'(got), 32'd1);
        in_valid = 1'b0;
        repeat (4) cyc();
        chk("bp_drained", 32'(occupancy), 32'd0);

        // streaming: one word per cycle, occupancy held at one
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            mode   = 2'($urandom_range(0, 3));
            imm_in = 16'($urandom);
            cyc();
        end
        chk("stream_occ", 32'(occupancy), 32'd1);
        in_valid = 1'b0;
        cyc();
        cyc();

        // reset while full; the handshake at the reset edge is discarded
        out_ready = 1'b0;
        in_valid  = 1'b1;
        imm_in = 16'($urandom);
        cyc();
        imm_in = 16'($urandom);
        cyc();
        chk("rst_mid_full", 32'(occupancy), 32'd2);
        rst = 1'b1;
        cyc();
        chk("rst_mid_occ", 32'(occupancy), 32'd0);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        rst    = 1'b0;
        d      = 16'($urandom);
        mode   = 2'd1;
        imm_in = d;
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("rst_mid_first", last_out, ref_ext(2'd1, d));

        // random soak with occasional reset
        for (int k = 0; k < 300; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            mode      = 2'($urandom_range(0, 3));
            imm_in    = 16'($urandom);
            rst       = ($urandom_range(0, 49) == 0);
            cyc();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cyc();
        chk("soak_drained", 32'(exp_q.size()), 32'(occupancy));

        // narrow instance: IN_W=8 OUT_W=16 SHIFT_BR=1
        v8    = 1'b1;
        imm8  = 8'h80;
        mode8 = 2'd1;
        cyc();
        chk("p8_sign", 32'(out8), 32'h0000FF80);
        imm8  = 8'h81;
        mode8 = 2'd3;
        cyc();
        chk("p8_branch", 32'(out8), 32'h0000FF02);
        chk("p8_occ_one", 32'(occ8), 32'd1);
        v8 = 1'b0;
        cyc();
        chk("p8_empty", 32'(occ8), 32'd0);
        chk("p8_zero_out", 32'(out8), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
